// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the sequential multi-precision adder.
package multiword_add_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default geometry: 4-bit chunks, 4 chunks -> 16-bit operands
    localparam int N_DEF     = 4;
    localparam int WORDS_DEF = 4;

    // Two's-complement overflow from the MSBs of A, effective B and the sum:
    // operands of equal sign producing a result of the other sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/multiword_add_seq.sv
// Sequential multi-precision adder controller. Streams N-bit chunks of two
// W-bit operands (LSB chunk first) through an external N-bit ripple-carry
// adder, chaining the carry between cycles, and presents the full result
// with carry-out and signed-overflow flags.
// Optional build macro: MULTIWORD_SUB_EN adds a 'sub' input selecting A-B.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF,
    localparam int W    = N * WORDS,
    localparam int IW   = $clog2(WORDS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef MULTIWORD_SUB_EN
    input  logic         sub,
`endif
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_s,
    input  logic         add_cout
);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           sub_q, sub_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           cout_q, cout_d;
    logic           ovf_q, ovf_d;

    logic           sub_in;
    logic           accept;
    logic           last_chunk;

`ifdef MULTIWORD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // A new operation may begin from IDLE or directly out of DONE
    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_chunk = (idx_q == IW'(WORDS - 1));

    // Adder feed: current chunk of each operand while running, zero otherwise
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q*N +: N];
            add_b   = b_q[idx_q*N +: N] ^ {N{sub_q}};
            add_cin = carry_q;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub_in;
                    // Subtraction is A + ~B + 1: the +1 enters as the first carry
                    carry_d = sub_in;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[idx_q*N +: N] = add_s;
                carry_d             = add_cout;
                if (last_chunk) begin
                    // Flags come straight from the MSB chunk as it is captured
                    cout_d  = add_cout;
                    ovf_d   = add_ovf(add_a[N-1], add_b[N-1], add_s[N-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (N=4, WORDS=4). A behavioural 4-bit
// adder closes the loop between add_* outputs and add_s/add_cout.
module tb_multiword_add_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a, b;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;
    logic [N-1:0] add_a, add_b, add_s;
    logic         add_cin, add_cout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Sibling chunk adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

    multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef MULTIWORD_SUB_EN
        .sub      (sub),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    // Drive one start pulse; returns after the accepting edge (at a negedge)
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; ok=0 if it never arrives
    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, done, cout, overflow} !== 4'b0000) begin n_err++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, cout, overflow}); end
        n_cmp++; if (sum !== 16'h0000) begin n_err++;
            $display("FAIL reset_sum got %h want 0000", sum); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0) begin n_err++;
            $display("FAIL idle_add_ports got %h want 0", {add_a, add_b, add_cin}); end
    endtask

    // Case 1: latency and busy/done timing for 0x00FF + 0x0001
    task automatic test_latency();
        logic ok;
        start_op(16'h00FF, 16'h0001, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < WORDS; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++;
            $display("FAIL busy_window got not-busy or early done want busy for %0d cycles", WORDS); end
        n_cmp++; if ({busy, done} !== 2'b01) begin n_err++;
            $display("FAIL done_latency got busy=%b done=%b want busy=0 done=1", busy, done); end
        n_cmp++; if ({sum, cout, overflow} !== {16'h0100, 1'b0, 1'b0}) begin n_err++;
            $display("FAIL add_00ff got %h c%b v%b want 0100 c0 v0", sum, cout, overflow); end
        @(negedge clk);
        n_cmp++; if ({done, sum} !== {1'b0, 16'h0100}) begin n_err++;
            $display("FAIL done_pulse_hold got done=%b sum=%h want done=0 sum=0100", done, sum); end
    endtask

    // Cases 2 and 3: carry ripple and signed overflow
    task automatic test_flags();
        logic ok;
        start_op(16'hFFFF, 16'h0001, 1'b0); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h0000, 1'b1, 1'b0}) begin n_err++;
            $display("FAIL ripple got ok=%b %h c%b v%b want 0000 c1 v0", ok, sum, cout, overflow); end
        start_op(16'h7FFF, 16'h0001, 1'b0); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h8000, 1'b0, 1'b1}) begin n_err++;
            $display("FAIL pos_ovf got ok=%b %h c%b v%b want 8000 c0 v1", ok, sum, cout, overflow); end
        start_op(16'h8000, 16'h8000, 1'b0); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h0000, 1'b1, 1'b1}) begin n_err++;
            $display("FAIL neg_ovf got ok=%b %h c%b v%b want 0000 c1 v1", ok, sum, cout, overflow); end
        start_op(16'h1234, 16'h4321, 1'b0); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h5555, 1'b0, 1'b0}) begin n_err++;
            $display("FAIL plain got ok=%b %h c%b v%b want 5555 c0 v0", ok, sum, cout, overflow); end
    endtask

    // Case 4: start ignored mid-run, then back-to-back from DONE
    task automatic test_back_to_back();
        logic ok;
        start_op(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok || sum !== 16'h2345) begin n_err++;
            $display("FAIL ignore_start got ok=%b sum=%h want 2345", ok, sum); end
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if ({busy, done} !== 2'b10) begin n_err++;
            $display("FAIL b2b_accept got busy=%b done=%b want busy=1 done=0", busy, done); end
        wait_done(ok);
        n_cmp++; if (!ok || {sum, cout} !== {16'h0003, 1'b0}) begin n_err++;
            $display("FAIL b2b_result got ok=%b sum=%h c%b want 0003 c0", ok, sum, cout); end
    endtask

    // Case 5: synchronous reset mid-operation, then recovery
    task automatic test_reset_mid();
        logic ok;
        start_op(16'hAAAA, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({busy, done, cout, overflow, sum} !== {4'b0000, 16'h0000}) begin n_err++;
            $display("FAIL abort_outputs got b%b d%b c%b v%b sum=%h want all 0", busy, done, cout, overflow, sum); end
        n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0) begin n_err++;
            $display("FAIL abort_add_ports got %h want 0", {add_a, add_b, add_cin}); end
        start_op(16'h0F0F, 16'h0101, 1'b0); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h1010, 1'b0, 1'b0}) begin n_err++;
            $display("FAIL recover got ok=%b %h c%b v%b want 1010 c0 v0", ok, sum, cout, overflow); end
    endtask

`ifdef MULTIWORD_SUB_EN
    // Case 6: subtraction
    task automatic test_sub();
        logic ok;
        start_op(16'h0005, 16'h0007, 1'b1); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout} !== {16'hFFFE, 1'b0}) begin n_err++;
            $display("FAIL sub_borrow got ok=%b %h c%b want FFFE c0", ok, sum, cout); end
        start_op(16'h0007, 16'h0005, 1'b1); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout} !== {16'h0002, 1'b1}) begin n_err++;
            $display("FAIL sub_noborrow got ok=%b %h c%b want 0002 c1", ok, sum, cout); end
        start_op(16'h8000, 16'h0001, 1'b1); wait_done(ok);
        n_cmp++; if (!ok || {sum, cout, overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin n_err++;
            $display("FAIL sub_ovf got ok=%b %h c%b v%b want 7FFF c1 v1", ok, sum, cout, overflow); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_flags();
        test_back_to_back();
        test_reset_mid();
`ifdef MULTIWORD_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
